// File: rtl/simon_round_engine.sv
// ---------------------------------------------------------------------------
// simon_round_engine
//
// Iterative SIMON64/128 block engine. A 64-bit block is accepted over a
// valid/ready handshake, one Feistel round is applied per clock using the
// round key that the integration level muxes back in for rk_idx, and the
// result is offered on a second valid/ready handshake.
//
// Build option:
//   SIMON_DECRYPT_EN  defined     -> 'decrypt' is latched at acceptance and
//                                    selects the inverse round with
//                                    descending round-key indices.
//                     not defined -> encrypt-only; 'decrypt' is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_block is valid
//   in_ready   engine can accept a block (IDLE)
//   in_block   [0:63] x = [0:31], y = [32:63]; bit 0 is the MSB
//   decrypt    mode, sampled together with in_block
//   rk_idx     index of the round key needed this cycle (0 outside RUN)
//   rk         round key for rk_idx, combinational from key expansion
//   out_valid  out_block is valid (DONE)
//   out_ready  downstream accepts the result
//   out_block  [0:63] result, x = [0:31], y = [32:63]
//   busy       high while rounds are being applied (RUN)
// ---------------------------------------------------------------------------
module simon_round_engine #(
    parameter int ROUNDS = 44,
    parameter int WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:2*WIDTH-1] in_block,
    input  logic               decrypt,
    output logic [5:0]         rk_idx,
    input  logic [0:WIDTH-1]   rk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:2*WIDTH-1] out_block,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    state_t           state;
    logic [0:WIDTH-1] x;
    logic [0:WIDTH-1] y;
    logic [5:0]       round;

    logic [0:WIDTH-1] x_next;
    logic [0:WIDTH-1] y_next;
    logic [5:0]       first_idx;
    logic [5:0]       next_idx;

`ifdef SIMON_DECRYPT_EN
    logic dec_mode;
`else
    // Mode input is accepted for port compatibility but has no effect.
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    // Left rotation; with bit 0 as the MSB this is the usual numeric rotl.
    function automatic logic [0:WIDTH-1] rotl(input logic [0:WIDTH-1] v,
                                              input int unsigned      n);
        return (v << n) | (v >> (WIDTH - n));
    endfunction

    function automatic logic [0:WIDTH-1] simon_f(input logic [0:WIDTH-1] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        x_next    = y ^ simon_f(x) ^ rk;
        y_next    = x;
        first_idx = '0;
        next_idx  = round + 6'd1;
`ifdef SIMON_DECRYPT_EN
        // Inverse round: undo x <- y ^ f(x) ^ k, y <- x with keys reversed.
        if (dec_mode) begin
            y_next   = x ^ simon_f(y) ^ rk;
            x_next   = y;
            next_idx = LAST - round - 6'd1;
        end
        if (decrypt) begin
            first_idx = LAST;
        end
`endif
    end

    assign out_block = {x, y};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // The x/y datapath registers are reset too: a reset mid-operation must
    // leave no trace of the partial result on out_block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            round     <= '0;
            rk_idx    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SIMON_DECRYPT_EN
            dec_mode  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= in_block[0:WIDTH-1];
                        y        <= in_block[WIDTH:2*WIDTH-1];
                        round    <= '0;
                        rk_idx   <= first_idx;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef SIMON_DECRYPT_EN
                        dec_mode <= decrypt;
`endif
                    end
                end
                RUN: begin
                    x <= x_next;
                    y <= y_next;
                    if (round == LAST) begin
                        round     <= '0;
                        rk_idx    <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        round  <= round + 6'd1;
                        rk_idx <= next_idx;
                    end
                end
                DONE: begin
                    // Result held until taken; next acceptance is a cycle later.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_round_engine.sv
// ---------------------------------------------------------------------------
// tb_simon_round_engine
//
// Self-checking bench for simon_round_engine. The bench plays the key
// expansion stage (full SIMON64/128 key schedule, rk driven from rk_idx) and
// keeps a transaction-level model: every accepted block gets its expected
// result from a plain software SIMON, and a per-cycle monitor checks the
// handshake/busy/rk_idx timeline and the result against it.
// ---------------------------------------------------------------------------
module tb_simon_round_engine;

    localparam int ROUNDS = 44;
`ifdef SIMON_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif
    localparam logic [127:0] TV_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  TV_PT  = 64'h656b696c_20646e75;
    localparam logic [63:0]  TV_CT  = 64'h44c8fc20_b9dfa07a;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [0:63] in_block  = '0;
    logic        decrypt   = 1'b0;
    logic [5:0]  rk_idx;
    logic [0:31] rk;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:63] out_block;
    logic        busy;

    logic [31:0] round_keys [0:ROUNDS-1];

    int checks = 0;
    int passed = 0;
    int cycle  = 0;
    bit rand_bp = 1'b0;

    always #5 clk = ~clk;

    simon_round_engine #(.ROUNDS(ROUNDS), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .decrypt   (decrypt),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    // Key expansion stand-in: combinational lookup of the selected key.
    assign rk = (int'(rk_idx) < ROUNDS) ? round_keys[rk_idx] : 32'h0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] f(input logic [31:0] v);
        return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [61:0] z3;
        logic [31:0] tmp;
        logic [31:0] zb;
        z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
        for (int i = 0; i < 4; i++) round_keys[i] = key[32*i +: 32];
        for (int i = 4; i < ROUNDS; i++) begin
            tmp = ror(round_keys[i-1], 3) ^ round_keys[i-3];
            tmp = tmp ^ ror(tmp, 1);
            zb  = {31'b0, z3[61 - ((i - 4) % 62)]};
            round_keys[i] = ~round_keys[i-4] ^ tmp ^ zb ^ 32'd3;
        end
    endtask

    function automatic logic [63:0] simon_ref(input logic [63:0] blk, input bit dec);
        logic [31:0] x, y, t;
        x = blk[63:32];
        y = blk[31:0];
        for (int r = 0; r < ROUNDS; r++) begin
            if (!dec) begin
                t = x;
                x = y ^ f(x) ^ round_keys[r];
                y = t;
            end else begin
                t = y;
                y = x ^ f(y) ^ round_keys[ROUNDS-1-r];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle monitor ----------------
    logic [63:0] exp_q [$];
    int          rise_q [$];
    bit          active   = 1'b0;
    bit          mode_dec = 1'b0;
    bit          prev_ov  = 1'b0;
    int          n        = 0;

    always begin
        @(negedge clk);
        cycle++;
        if (!rst_n) begin
            check("rst_in_ready",  in_ready,  1);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy",      busy,      0);
            check("rst_rk_idx",    rk_idx,    0);
            check("rst_out_block", out_block, 0);
            active  = 1'b0;
            prev_ov = 1'b0;
            exp_q.delete();
        end else begin
            if (out_valid && !prev_ov) rise_q.push_back(cycle);
            prev_ov = out_valid;
            if (active) begin
                n++;
                if (n <= ROUNDS) begin
                    check("run_busy",      busy,      1);
                    check("run_in_ready",  in_ready,  0);
                    check("run_out_valid", out_valid, 0);
                    check("run_rk_idx",    rk_idx,    mode_dec ? (ROUNDS - n) : (n - 1));
                end else begin
                    check("done_out_valid", out_valid, 1);
                    check("done_in_ready",  in_ready,  0);
                    check("done_busy",      busy,      0);
                    check("done_rk_idx",    rk_idx,    0);
                    if (exp_q.size() > 0) check("done_out_block", out_block, exp_q[0]);
                    else check("scoreboard_nonempty", exp_q.size(), 1);
                    if (out_ready) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        active = 1'b0;
                    end
                end
            end else begin
                check("idle_in_ready",  in_ready,  1);
                check("idle_out_valid", out_valid, 0);
                check("idle_busy",      busy,      0);
                check("idle_rk_idx",    rk_idx,    0);
                if (in_valid) begin
                    active   = 1'b1;
                    n        = 0;
                    mode_dec = decrypt && DEC_EN;
                    exp_q.push_back(simon_ref(in_block, mode_dec));
                end
            end
        end
    end

    // Random backpressure during the randomized phase.
    always begin
        @(posedge clk);
        #2;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 400) begin
            step();
            guard++;
        end
        check("in_ready_seen", in_ready, 1);
    endtask

    task automatic send(input logic [63:0] blk, input logic dec);
        in_valid = 1'b1;
        in_block = blk;
        decrypt  = dec;
        wait_ready();
        step();
        in_valid = 1'b0;
        decrypt  = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            step();
            cycles++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    initial begin
        logic [63:0] snap, blk, blk_b;
        int lat;

        #1 rst_n = 1'b0;
        expand(TV_KEY);
        check("model_k0",     round_keys[0], 32'h03020100);
        check("model_enc_tv", simon_ref(TV_PT, 1'b0), TV_CT);
        check("model_dec_tv", simon_ref(TV_CT, 1'b1), TV_PT);
        step();
        step();
        check("reset_in_ready",  in_ready,  1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_block", out_block, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Known-answer encrypt with latency.
        send(TV_PT, 1'b0);
        wait_out(lat);
        check("enc_latency", lat, 44);
        check("enc_tv", out_block, TV_CT);
        step();

        // Decrypt (or encrypt of the ciphertext when decrypt is not built).
        send(TV_CT, 1'b1);
        wait_out(lat);
        check("dec_tv", out_block, DEC_EN ? TV_PT : simon_ref(TV_CT, 1'b0));
        step();

        // Backpressure with an ignored in_valid pulse.
        out_ready = 1'b0;
        blk = {$urandom, $urandom};
        send(blk, 1'b0);
        wait_out(lat);
        snap = out_block;
        for (int i = 0; i < 20; i++) begin
            step();
            in_valid = (i == 5);
            in_block = {$urandom, $urandom};
        end
        in_valid = 1'b0;
        check("bp_hold",      out_block, snap);
        check("bp_result",    out_block, simon_ref(blk, 1'b0));
        check("bp_in_ready",  in_ready,  0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready",  in_ready,  1);
        check("bp_release_out_valid", out_valid, 0);

        // Asynchronous reset at round 20.
        send({$urandom, $urandom}, 1'b0);
        repeat (20) step();
        check("pre_reset_busy",   busy,   1);
        check("pre_reset_rk_idx", rk_idx, 20);
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready",  in_ready,  1);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_busy",      busy,      0);
        check("async_rst_rk_idx",    rk_idx,    0);
        check("async_rst_out_block", out_block, 0);
        step();
        rst_n = 1'b1;
        step();
        send(TV_PT, 1'b0);
        wait_out(lat);
        check("post_reset_enc", out_block, TV_CT);
        step();

        // Back-to-back with in_valid and out_ready held high.
        blk   = {$urandom, $urandom};
        blk_b = {$urandom, $urandom};
        in_valid = 1'b1;
        in_block = blk;
        wait_ready();
        step();
        in_block = blk_b;
        decrypt  = 1'($urandom_range(0, 1));
        wait_ready();
        step();
        in_valid = 1'b0;
        decrypt  = 1'b0;
        wait_out(lat);
        step();
        if (rise_q.size() >= 2) check("b2b_spacing", rise_q[$] - rise_q[$-1], 46);
        else check("b2b_two_results", rise_q.size(), 2);

        // Randomized blocks, modes, keys and backpressure.
        rand_bp = 1'b1;
        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 0) begin
                wait_ready();
                expand({$urandom, $urandom, $urandom, $urandom});
            end
            send({$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        wait_ready();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
